// File: rtl/gcd_engine.sv
// gcd_engine: self-controlled GCD unit with a selectable algorithm.
// MODE 0 runs subtractive Euclid, MODE 1 runs binary (Stein) GCD.
// One operation is in flight at a time. The engine loads an operand pair in
// IDLE, steps once per cycle in CALC, and presents the result in DONE until
// the consumer takes it.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid && ready are both high. The producer holds x_in/y_in stable
// while in_valid is high. The engine holds gcd_out/iter_cnt stable while
// out_valid is high. in_valid is only looked at in IDLE, and out_ready is
// only looked at in DONE.
module gcd_engine #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_cnt
);

  // k counts common factors of two stripped in binary mode.
  // It never reaches WIDTH, so this width leaves headroom.
  localparam int unsigned K_W = $clog2(WIDTH) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             out_valid_q, out_valid_d;

  // Single step of the selected algorithm, shown as a terminate flag plus a
  // result and as next operand values.
  logic             step_done;
  logic [WIDTH-1:0] step_res;
  logic [WIDTH-1:0] step_x;
  logic [WIDTH-1:0] step_y;
  logic [K_W-1:0]   step_k;

  // One algorithm step on the current operands. Rules are listed highest
  // priority first. Subtraction is always larger minus smaller.
  always_comb begin
    step_done = 1'b0;
    step_res  = '0;
    step_x    = x_q;
    step_y    = y_q;
    step_k    = k_q;
    if (MODE == 0) begin
      if (x_q == '0) begin
        step_done = 1'b1;
        step_res  = y_q;
      end else if (y_q == '0) begin
        step_done = 1'b1;
        step_res  = x_q;
      end else if (x_q == y_q) begin
        step_done = 1'b1;
        step_res  = x_q;
      end else if (x_q > y_q) begin
        step_x = x_q - y_q;
      end else begin
        step_y = y_q - x_q;
      end
    end else begin
      if (x_q == '0) begin
        step_done = 1'b1;
        step_res  = y_q << k_q;
      end else if (y_q == '0) begin
        step_done = 1'b1;
        step_res  = x_q << k_q;
      end else if (x_q == y_q) begin
        step_done = 1'b1;
        step_res  = x_q << k_q;
      end else if (!x_q[0] && !y_q[0]) begin
        step_x = x_q >> 1;
        step_y = y_q >> 1;
        step_k = k_q + K_W'(1);
      end else if (!x_q[0]) begin
        step_x = x_q >> 1;
      end else if (!y_q[0]) begin
        step_y = y_q >> 1;
      end else if (x_q > y_q) begin
        step_x = (x_q - y_q) >> 1;
      end else begin
        step_y = (y_q - x_q) >> 1;
      end
    end
  end

  // Next-state and next-register logic for the IDLE/CALC/DONE controller.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    k_d         = k_q;
    gcd_d       = gcd_q;
    iter_d      = iter_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          y_d     = y_in;
          k_d     = '0;
          iter_d  = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Counts every CALC cycle including the terminating one, saturating.
        iter_d = (iter_q == CNT_MAX) ? iter_q : iter_q + CNT_W'(1);
        x_d    = step_x;
        y_d    = step_y;
        k_d    = step_k;
        if (step_done) begin
          gcd_d       = step_res;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers. Reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      k_q         <= '0;
      gcd_q       <= '0;
      iter_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      k_q         <= k_d;
      gcd_q       <= gcd_d;
      iter_q      <= iter_d;
      out_valid_q <= out_valid_d;
    end
  end

  // in_ready is gated by rst so it reads 0 for the whole reset pulse and 1
  // in the first cycle after release.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign gcd_out   = gcd_q;
  assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine. Three instances share one stimulus bus:
//   dut0: WIDTH=32 MODE=0 CNT_W=16
//   dut1: WIDTH=32 MODE=1 CNT_W=16
//   dut2: WIDTH=8  MODE=0 CNT_W=4 (saturating counter)
// Operands stay within 0..255, so all three compute the same GCD.
module tb_gcd_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] x_in;
  logic [31:0] y_in;

  logic [2:0]  in_ready_a;
  logic [2:0]  out_valid_a;
  logic [31:0] gcd_a  [3];
  logic [15:0] iter_a [3];

  logic [31:0] gcd_0, gcd_1;
  logic [15:0] iter_0, iter_1;
  logic [7:0]  gcd_2;
  logic [3:0]  iter_2;

  int total = 0;
  int bad   = 0;
  int lat_a [3];
  int cmax  [3] = '{65535, 65535, 15};
  int mode_a[3] = '{0, 1, 0};

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(32), .MODE(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[0]),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid_a[0]), .out_ready(out_ready),
    .gcd_out(gcd_0), .iter_cnt(iter_0));

  gcd_engine #(.WIDTH(32), .MODE(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[1]),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid_a[1]), .out_ready(out_ready),
    .gcd_out(gcd_1), .iter_cnt(iter_1));

  gcd_engine #(.WIDTH(8), .MODE(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[2]),
    .x_in(x_in[7:0]), .y_in(y_in[7:0]), .out_valid(out_valid_a[2]), .out_ready(out_ready),
    .gcd_out(gcd_2), .iter_cnt(iter_2));

  assign gcd_a[0]  = gcd_0;
  assign gcd_a[1]  = gcd_1;
  assign gcd_a[2]  = {24'd0, gcd_2};
  assign iter_a[0] = iter_0;
  assign iter_a[1] = iter_1;
  assign iter_a[2] = {12'd0, iter_2};

  // ---------------- reference model ----------------

  // Mathematical GCD by division; gcd(0,0)=0.
  function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtractive cycle count: the sum of division quotients equals the
  // subtractions plus the terminating cycle. A zero operand costs one cycle.
  function automatic int ref_sub_steps(input int unsigned a, input int unsigned b);
    int unsigned t;
    int s;
    if (a == 0 || b == 0) return 1;
    s = 0;
    while (b != 0) begin
      s += int'(a / b);
      t = a % b;
      a = b;
      b = t;
    end
    return s;
  endfunction

  // Binary GCD cycle count, from the stated step rules.
  function automatic int ref_stein_steps(input int unsigned a, input int unsigned b);
    int n;
    n = 0;
    forever begin
      n++;
      if (a == 0 || b == 0 || a == b) return n;
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a > b) a = (a - b) / 2;
      else b = (b - a) / 2;
    end
  endfunction

  function automatic int ref_steps(input int i, input int unsigned a, input int unsigned b);
    return (mode_a[i] == 1) ? ref_stein_steps(a, b) : ref_sub_steps(a, b);
  endfunction

  function automatic int ref_iter(input int i, input int unsigned a, input int unsigned b);
    int n;
    n = ref_steps(i, a, b);
    return (n > cmax[i]) ? cmax[i] : n;
  endfunction

  // ---------------- driver tasks ----------------

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    x_in     = a;
    y_in     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called just after the accepting edge. The cycle of the accepting edge
  // counts as 1. The first cycle with out_valid high is recorded for each
  // instance, and out_ready is held low so results stay put.
  task automatic wait_results();
    int  cyc;
    bit  all_seen;
    for (int i = 0; i < 3; i++) lat_a[i] = 0;
    cyc = 1;
    while (cyc < 3000) begin
      all_seen = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (out_valid_a[i] === 1'b1 && lat_a[i] == 0) lat_a[i] = cyc;
        if (lat_a[i] == 0) all_seen = 1'b0;
      end
      if (all_seen) break;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready_a[i] !== 1'b0 || out_valid_a[i] !== 1'b0 ||
          gcd_a[i] !== 32'd0 || iter_a[i] !== 16'd0) begin
        bad++;
        $display("FAIL reset_state dut%0d got rdy=%b vld=%b gcd=%0d iter=%0d exp 0 0 0 0",
                 i, in_ready_a[i], out_valid_a[i], gcd_a[i], iter_a[i]);
      end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready_a[i] !== 1'b1) begin
        bad++;
        $display("FAIL reset_release_ready dut%0d got=%b exp=1", i, in_ready_a[i]);
      end
    end
  endtask

  task automatic test_basic();
    int exp_iter[3] = '{3, 4, 3};
    send(32'd12, 32'd18);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready_a[i] !== 1'b0) begin
        bad++;
        $display("FAIL basic_busy dut%0d got in_ready=%b exp=0", i, in_ready_a[i]);
      end
    end
    wait_results();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid_a[i] !== 1'b1 || gcd_a[i] !== 32'd6 || iter_a[i] !== 16'(exp_iter[i])) begin
        bad++;
        $display("FAIL basic_result dut%0d got vld=%b gcd=%0d iter=%0d exp 1 6 %0d",
                 i, out_valid_a[i], gcd_a[i], iter_a[i], exp_iter[i]);
      end
      total++;
      if (lat_a[i] != exp_iter[i] + 1) begin
        bad++;
        $display("FAIL basic_latency dut%0d got=%0d exp=%0d", i, lat_a[i], exp_iter[i] + 1);
      end
    end
    release_result();
  endtask

  task automatic test_zero();
    int unsigned za[3] = '{0, 0, 9};
    int unsigned zb[3] = '{0, 7, 0};
    int unsigned zr[3] = '{0, 7, 9};
    for (int v = 0; v < 3; v++) begin
      send(za[v], zb[v]);
      wait_results();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (out_valid_a[i] !== 1'b1 || gcd_a[i] !== zr[v] || iter_a[i] !== 16'd1 || lat_a[i] != 2) begin
          bad++;
          $display("FAIL zero_operand dut%0d (%0d,%0d) got vld=%b gcd=%0d iter=%0d lat=%0d exp 1 %0d 1 2",
                   i, za[v], zb[v], out_valid_a[i], gcd_a[i], iter_a[i], lat_a[i], zr[v]);
        end
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_gcd[3];
    logic [15:0] held_iter[3];
    send(32'd20, 32'd15);
    wait_results();
    for (int i = 0; i < 3; i++) begin
      held_gcd[i]  = gcd_a[i];
      held_iter[i] = iter_a[i];
      total++;
      if (gcd_a[i] !== 32'd5 || iter_a[i] !== 16'(ref_iter(i, 20, 15))) begin
        bad++;
        $display("FAIL bp_result dut%0d got gcd=%0d iter=%0d exp 5 %0d",
                 i, gcd_a[i], iter_a[i], ref_iter(i, 20, 15));
      end
    end
    // Offer new operands while the result is stalled.
    x_in = 32'd48; y_in = 32'd36; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (out_valid_a[i] !== 1'b1 || in_ready_a[i] !== 1'b0 ||
            gcd_a[i] !== held_gcd[i] || iter_a[i] !== held_iter[i]) begin
          bad++;
          $display("FAIL bp_hold dut%0d got vld=%b rdy=%b gcd=%0d iter=%0d exp 1 0 %0d %0d",
                   i, out_valid_a[i], in_ready_a[i], gcd_a[i], iter_a[i], held_gcd[i], held_iter[i]);
        end
      end
    end
    // Handshake edge: the pending input must not be taken on this edge.
    release_result();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid_a[i] !== 1'b0 || in_ready_a[i] !== 1'b1) begin
        bad++;
        $display("FAIL bp_after_handshake dut%0d got vld=%b rdy=%b exp 0 1",
                 i, out_valid_a[i], in_ready_a[i]);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready_a[i] !== 1'b0) begin
        bad++;
        $display("FAIL bp_accept dut%0d got in_ready=%b exp=0", i, in_ready_a[i]);
      end
    end
    wait_results();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (gcd_a[i] !== 32'd12 || iter_a[i] !== 16'(ref_iter(i, 48, 36))) begin
        bad++;
        $display("FAIL bp_next_result dut%0d got gcd=%0d iter=%0d exp 12 %0d",
                 i, gcd_a[i], iter_a[i], ref_iter(i, 48, 36));
      end
    end
    release_result();
  endtask

  task automatic test_saturation();
    send(32'd1, 32'd255);
    wait_results();
    total++;
    if (gcd_a[2] !== 32'd1 || iter_a[2] !== 16'd15 || lat_a[2] != 256) begin
      bad++;
      $display("FAIL saturation dut2 got gcd=%0d iter=%0d lat=%0d exp 1 15 256",
               gcd_a[2], iter_a[2], lat_a[2]);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (gcd_a[i] !== 32'd1 || iter_a[i] !== 16'(ref_iter(i, 1, 255))) begin
        bad++;
        $display("FAIL saturation_wide dut%0d got gcd=%0d iter=%0d exp 1 %0d",
                 i, gcd_a[i], iter_a[i], ref_iter(i, 1, 255));
      end
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    bit seen;
    send(32'd1, 32'd255);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid_a[i] !== 1'b0 || gcd_a[i] !== 32'd0 || iter_a[i] !== 16'd0 || in_ready_a[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_clear dut%0d got vld=%b gcd=%0d iter=%0d rdy=%b exp 0 0 0 0",
                 i, out_valid_a[i], gcd_a[i], iter_a[i], in_ready_a[i]);
      end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready_a[i] !== 1'b1) begin
        bad++;
        $display("FAIL reset_mid_ready dut%0d got=%b exp=1", i, in_ready_a[i]);
      end
    end
    seen = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (out_valid_a !== 3'b000) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_mid_no_result got out_valid seen=1 exp=0");
    end
    send(32'd48, 32'd36);
    wait_results();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid_a[i] !== 1'b1 || gcd_a[i] !== 32'd12 || iter_a[i] !== 16'(ref_iter(i, 48, 36))) begin
        bad++;
        $display("FAIL reset_mid_next dut%0d got vld=%b gcd=%0d iter=%0d exp 1 12 %0d",
                 i, out_valid_a[i], gcd_a[i], iter_a[i], ref_iter(i, 48, 36));
      end
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int unsigned a, b, g;
    for (int n = 0; n < 14; n++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if (n % 5 == 4) b = a;
      g = ref_gcd(a, b);
      total++;
      if (in_ready_a !== 3'b111) begin
        bad++;
        $display("FAIL b2b_ready op%0d got=%b exp=111", n, in_ready_a);
      end
      send(a, b);
      wait_results();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (out_valid_a[i] !== 1'b1 || gcd_a[i] !== g || iter_a[i] !== 16'(ref_iter(i, a, b)) ||
            lat_a[i] != ref_steps(i, a, b) + 1) begin
          bad++;
          $display("FAIL b2b_result dut%0d (%0d,%0d) got vld=%b gcd=%0d iter=%0d lat=%0d exp 1 %0d %0d %0d",
                   i, a, b, out_valid_a[i], gcd_a[i], iter_a[i], lat_a[i], g,
                   ref_iter(i, a, b), ref_steps(i, a, b) + 1);
        end
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
